// File: rtl/iiitb_bidicntr.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_bidicntr
// Purpose  : Synchronous up/down binary counter with asynchronous active-low
//            reset. A one-cycle pulse on wrap flags every edge on which the
//            counter crossed its modulo boundary.
//
// Ports    : clk    in   1      system clock, rising-edge active
//            reset  in   1      asynchronous active-low reset
//            ctrl   in   1      direction: 0 = count up, 1 = count down
//            count  out  WIDTH  registered counter value
//            wrap   out  1      registered one-cycle boundary pulse
//
// Params   : WIDTH  counter width in bits, 2..32 (default 4)
//
// Build    : IIITB_BIDICNTR_SATURATE_EN
//              undefined - modulo 2^WIDTH wrap-around (default)
//              defined   - saturating counter; holds at all-ones / zero and
//                          pulses wrap on every edge it is held at a limit
//
// Revision : 1.0  initial release
// ============================================================================
module iiitb_bidicntr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic             w_at_limit;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next_count;

    // The limit depends on direction: all-ones is the boundary going up,
    // zero is the boundary going down.
    assign w_at_limit = ctrl ? (r_count == c_ZERO) : (r_count == c_ALL_ONES);

    // Natural width arithmetic discards the carry/borrow, giving modulo wrap.
    assign w_step = ctrl ? (r_count - c_ONE) : (r_count + c_ONE);

`ifdef IIITB_BIDICNTR_SATURATE_EN
    // Hold at the limit instead of wrapping.
    assign w_next_count = w_at_limit ? r_count : w_step;
`else
    assign w_next_count = w_step;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= c_ZERO;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            // Both modes flag the same condition: the edge met the boundary.
            r_wrap  <= w_at_limit;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_bidicntr.sv
`default_nettype none
// ============================================================================
// Module   : tb_iiitb_bidicntr
// Purpose  : Directed self-checking bench for iiitb_bidicntr (WIDTH = 4).
//            Expected count/wrap values come from a modulo-16 (or saturating)
//            reference model, queued when ctrl is driven and popped after
//            the clock edge that should produce them.
// Revision : 1.0  initial release
// ============================================================================
module tb_iiitb_bidicntr;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             ctrl;
    logic [WIDTH-1:0] count;
    logic             wrap;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             wr;
    } exp_t;

    exp_t sb[$];

    int errors    = 0;
    int checks    = 0;
    int m_count   = 0;
    int crossings = 0;
    int obs_wraps = 0;

    iiitb_bidicntr #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .count (count),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one direction value, predict the edge result, then compare.
    task automatic step(input logic c, input string tag);
        int   nxt;
        logic at;
        exp_t e;
        ctrl = c;
        at   = c ? (m_count == 0) : (m_count == MAXV);
`ifdef IIITB_BIDICNTR_SATURATE_EN
        if (at) nxt = m_count;
        else    nxt = c ? m_count - 1 : m_count + 1;
`else
        nxt = c ? (m_count + MAXV) % (MAXV + 1) : (m_count + 1) % (MAXV + 1);
`endif
        m_count = nxt;
        if (at) crossings++;
        sb.push_back('{cnt: nxt[WIDTH-1:0], wr: at});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_count"}, {28'd0, count}, {28'd0, e.cnt});
            chk({tag, "_wrap"}, {31'd0, wrap}, {31'd0, e.wr});
        end
        if (wrap === 1'b1) obs_wraps++;
    endtask

    task automatic run(input logic c, input int n, input string tag);
        for (int i = 0; i < n; i++) step(c, tag);
    endtask

    initial begin
        reset = 1'b0;
        ctrl  = 1'bx;

        // Reset held for two edges with ctrl unknown.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);

        @(negedge clk);
        reset   = 1'b1;
        m_count = 0;

        // Reach a wrap so a pulse is pending, then reset mid-cycle.
        run(1'b0, 16, "pre_wrap");
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_count", {28'd0, count}, 32'd0);
        chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
        ctrl = 1'bx;
        @(posedge clk);
        #1;
        chk("held_rst_count", {28'd0, count}, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        m_count = 0;
        sb.delete();

        // Up count: 1..15, 0, 1..4.
        run(1'b0, 20, "up");
        // Down: 3, 2, 1, 0, 15, 14, 13.
        run(1'b1, 7, "down");
        // Up to 7, then direction flips.
        run(1'b0, 10, "up_to7");
        run(1'b1, 2, "dir_dn");
        run(1'b0, 2, "dir_up");
        // Climb to the top boundary and turn around right there.
        run(1'b0, 8, "to_top");
        step(1'b1, "top_turn");
        run(1'b1, 14, "to_bot");
        step(1'b0, "bot_turn");

        // Long run with wrap tally.
        crossings = 0;
        obs_wraps = 0;
        run(1'b0, 125, "long_up");
        run(1'b1, 64, "long_dn");
        chk("wrap_tally", obs_wraps, crossings);

`ifdef IIITB_BIDICNTR_SATURATE_EN
        run(1'b0, 20, "sat_up");
        chk("sat_hi_count", {28'd0, count}, MAXV);
        chk("sat_hi_wrap", {31'd0, wrap}, 32'd1);
        run(1'b1, 20, "sat_dn");
        chk("sat_lo_count", {28'd0, count}, 32'd0);
        chk("sat_lo_wrap", {31'd0, wrap}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iiitb_bidicntr.md
# iiitb_bidicntr

Synchronous bidirectional (up/down) binary counter with asynchronous active-low reset. A single direction input selects increment or decrement on every rising clock edge; the counter wraps modulo 2^WIDTH and flags each wrap with a one-cycle pulse. Used as a general-purpose up/down count source and event counter in the datapath, driven from the system clock domain.

## Interface
- WIDTH, default 4: counter width in bits; legal range 2..32.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces all state to reset values immediately, regardless of clk.
- ctrl  input  1  direction select: 0 = count up, 1 = count down.
- count  output  WIDTH  current counter value, registered.
- wrap  output  1  registered one-cycle pulse, high in the cycle after an edge on which count wrapped (up: all-ones→0; down: 0→all-ones).

## Operation
- Reset value: count = 0, wrap = 0.
- Each rising clk edge with reset high:
  - ctrl = 0: count ← count + 1, modulo 2^WIDTH.
  - ctrl = 1: count ← count − 1, modulo 2^WIDTH.
- No hold state: count changes on every clock edge while out of reset.
- wrap is 1 for exactly one cycle after a wrap event, otherwise 0.
- Direction changes have no penalty; the new ctrl value applies on the next edge, with no lost or duplicated counts.
- ctrl is ignored while reset is low. It may be X during reset without affecting count.
- Unsigned arithmetic only. Carry/borrow beyond WIDTH bits is discarded except as reported by wrap.

## Timing
- Latency: one clock from ctrl sampling to the updated count.
- Reset assertion: count and wrap go to 0 asynchronously, without waiting for a clock edge.
- Reset deassertion: the first count change occurs on the first rising edge after reset goes high.
- Reset mid-count: count immediately returns to 0. Any pending wrap pulse is cleared.
- ctrl must meet setup/hold to clk. It is sampled only on rising edges.
- Boundaries, WIDTH = 4:
  - Up from 15 gives 0 with wrap = 1.
  - Down from 0 gives 15 with wrap = 1.
  - ctrl toggling on the cycle count sits at a boundary follows the direction sampled at that edge.

## Configuration
- Macro IIITB_BIDICNTR_SATURATE_EN.
- Undefined (default): modulo wrap-around behaviour as above.
- Defined: saturating counter.
  - Counting up at all-ones holds all-ones; counting down at 0 holds 0.
  - wrap pulses high for one cycle each edge the counter is held at a limit.
  - Reset behaviour is identical in both modes.

## Test plan
- Reset: hold reset = 0 for 2 cycles with ctrl = X → count = 0 and wrap = 0. Assert reset low asynchronously mid-cycle → count = 0 before the next edge.
- Up count: release reset, ctrl = 0, run 20 cycles → count goes 1, 2, … 15, 0, 1, …, 4. wrap = 1 only in the cycle after 15→0.
- Down count: from count = 3, set ctrl = 1 for 6 cycles → count goes 2, 1, 0, 15, 14, 13. wrap pulses once, after 0→15.
- Direction change: count up to 7, flip ctrl to 1 → next values are 6, 5. Flip back to 0 → 6, 7. No skipped or repeated values.
- Long run: ctrl = 0 for 125 cycles then ctrl = 1 for 64 cycles → count matches a modulo-16 reference model every cycle, and the wrap count equals the number of boundary crossings.
- Saturate build (IIITB_BIDICNTR_SATURATE_EN defined): count up 20 cycles → holds at 15 with wrap high each held cycle. ctrl = 1 for 20 cycles → holds at 0.
